// File: rtl/writeback_cycle.sv
// writeback_cycle: final pipeline stage, the writer side of the register-file
// port. ALU results are written one cycle after transfer. Loads are collected
// beat by beat from the data-memory return stream (1 beat scalar, LANES beats
// vector) and written once complete; the stage stalls the memory stage
// (ReadyM=0) while a load is being collected.
// Ports:
//   clk, rst                      clock, async active-high reset
//   ValidM / ReadyM               memory-stage handshake
//   RegWriteM, ResultSrcM,
//   vectorialM, RDM, ALUResultM   instruction fields from the memory stage
//   mem_rdata, mem_rvalid         data-memory return beats (lane 0 first)
//   RegWriteW, RDW, ResultW       registered register-file write port
module writeback_cycle #(
  parameter int DATA_W = 128,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 6,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidM,
  output logic              ReadyM,
  input  logic              RegWriteM,
  input  logic              ResultSrcM,
  input  logic              vectorialM,
  input  logic [ADDR_W-1:0] RDM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              RegWriteW,
  output logic [ADDR_W-1:0] RDW,
  output logic [DATA_W-1:0] ResultW
);

  localparam int CNT_W = $clog2(LANES + 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [ADDR_W-1:0]   ld_rd_q, ld_rd_d;
  logic                ld_we_q, ld_we_d;
  logic                ld_vec_q, ld_vec_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   rdw_q, rdw_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                last_beat;

  assign ReadyM    = (state_q == IDLE);
  assign RegWriteW = wr_q;
  assign RDW       = rdw_q;
  assign ResultW   = res_q;

  // Beat being received now completes the load.
  assign last_beat = ld_vec_q ? (cnt_q == CNT_W'(LANES - 1)) : (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      buf_q    <= '0;
      ld_rd_q  <= '0;
      ld_we_q  <= 1'b0;
      ld_vec_q <= 1'b0;
      wr_q     <= 1'b0;
      rdw_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      ld_rd_q  <= ld_rd_d;
      ld_we_q  <= ld_we_d;
      ld_vec_q <= ld_vec_d;
      wr_q     <= wr_d;
      rdw_q    <= rdw_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    ld_rd_d  = ld_rd_q;
    ld_we_d  = ld_we_q;
    ld_vec_d = ld_vec_q;
    wr_d     = 1'b0;
    // Address/data only move on an actual write; otherwise they hold.
    rdw_d    = rdw_q;
    res_d    = res_q;
    case (state_q)
      IDLE: begin
        if (ValidM) begin
          if (!ResultSrcM) begin
            if (RegWriteM && (RDM != '0)) begin
              wr_d  = 1'b1;
              rdw_d = RDM;
              res_d = ALUResultM;
            end
          end else begin
            ld_rd_d  = RDM;
            ld_we_d  = RegWriteM;
            ld_vec_d = vectorialM;
            buf_d    = '0;
            cnt_d    = '0;
            state_d  = LOAD;
          end
        end
      end
      LOAD: begin
        if (mem_rvalid) begin
          for (int l = 0; l < LANES; l++) begin
            if (cnt_q == CNT_W'(l)) buf_d[l*WORD_W +: WORD_W] = mem_rdata;
          end
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            state_d = IDLE;
            if (ld_we_q && (ld_rd_q != '0)) begin
              wr_d  = 1'b1;
              rdw_d = ld_rd_q;
              res_d = buf_d;   // includes the beat arriving this cycle
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
